fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the in-order RV32 core: holds the PC, issues single-outstanding word requests to instruction memory and presents fetched instructions to the IF/ID register. Sits directly upstream of the ID-stage branch resolver and consumes its taken flag and PC-relative offset to redirect fetch. When redirected, it squashes the wrong-path buffered instruction and any in-flight fetch.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- br_taken  in  1  ID-stage branch/jump/jalr taken flag
- br_offset  in  32  offset relative to br_pc; already target-adjusted for jalr
- br_pc  in  32  PC of the instruction in ID
- id_ready  in  1  ID accepts IF/ID contents this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  response valid; imem_rdata valid same cycle
- imem_rdata  in  32  fetched instruction
- if_valid  out  1  if_pc/if_instr hold a valid instruction
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction
- if_misalign  out  1  presented entry is a misaligned-target fault (macro only; else tied 0)

## Operation
- State machine: ISSUE, WAIT, DROP.
- ISSUE: imem_req=1, imem_addr=pc. Transition to WAIT at the clock edge if the output buffer is empty or drains this cycle (if_valid & id_ready); otherwise hold ISSUE with req=0.
- WAIT: imem_req=1, address stable until imem_ack. On ack: buffer {pc, rdata}, if_valid=1, pc+=4 (mod 2^32 wrap), go ISSUE.
- redirect = br_taken & id_ready. target = (br_pc + br_offset) & ~32'h1, 32-bit wrap.
- On redirect: buffer invalidated next cycle, pc <= target.
  - In ISSUE: go ISSUE and fetch target next cycle.
  - In WAIT without ack: go DROP.
  - In WAIT with simultaneous ack: rdata discarded, go ISSUE.
- DROP: imem_req=0; wait for ack, discard data, go ISSUE. A second redirect in DROP only updates pc.
- Redirect takes priority over normal buffer capture and pc increment.
- Buffer: one entry. It is cleared by id_ready when no new capture occurs.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), if_misalign=0, state=ISSUE, pc=RESET_PC.
- First imem_req=1 in the first cycle after rst_n deasserts.
- Earliest ack is one cycle after req rises. Minimum latency is ack-edge to if_valid=1: one cycle.
- Peak throughput: one instruction per 2 cycles.
- Redirect-to-req(target) latency: 1 cycle from ISSUE or ack-coincident; otherwise 1 cycle after the dropped ack.
- Asserting rst_n mid-transaction abandons the request. Memory is reset by the same rst_n, so no stale ack can arrive.

## Configuration
- FETCH_MISALIGN_CHECK_EN:
  - Defined: if target[1]=1, no fetch is issued. The buffer loads {target, NOP} with if_valid=1 and if_misalign=1, and the FSM waits in ISSUE until the next redirect.
  - Undefined: target[1] is forced to 0 and if_misalign is tied 0.

## Structure
- fetch_pkg: state enum (ISSUE/WAIT/DROP), NOP_INSTR constant, default RESET_PC.
- Single module; no sub-module required.

## Test plan
- Reset, then ack 1 cycle after each req -> addresses 8000_0000, _0004, _0008 in order; if_valid with matching if_pc.
- id_ready=0 for 5 cycles with buffer full -> imem_req stays 0. id_ready=1 -> next req to pc+4 in the same cycle.
- Redirect (br_pc=8000_0010, br_offset=-16) while WAIT, ack 3 cycles later -> that data dropped, if_valid=0, next req addr 8000_0000.
- Redirect coincident with ack (offset=+32, br_pc=8000_0004) -> rdata discarded, next cycle req addr 8000_0024.
- jalr-style odd target (br_pc+br_offset=8000_0101) -> addr 8000_0100. With macro defined, target 8000_0102 -> if_misalign=1, no req.
- rst_n asserted mid-WAIT -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus; master is the fetch stage, slave the memory.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch, one-entry IF/ID buffer.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets become a fault entry.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               br_taken,
  input  logic [31:0]        br_offset,
  input  logic [31:0]        br_pc,
  input  logic               id_ready,
  fetch_unit_if.master       imem,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_instr,
  output logic               if_misalign
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic         valid_nx, mis_nx, halt, halt_nx, req_c;
  logic [31:0]  bpc_nx, instr_nx;
  logic         redirect, tgt_fault;
  logic [31:0]  sum, target;

  assign redirect = br_taken & id_ready;
  assign sum      = br_pc + br_offset;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target    = sum & ~32'h1;
  assign tgt_fault = target[1];
`else
  assign target    = sum & ~32'h3;
  assign tgt_fault = 1'b0;
`endif

  // Request is held low while in reset so the bus idles regardless of FSM state.
  assign imem.req  = req_c & rst_n;
  assign imem.addr = pc;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    valid_nx = if_valid;
    bpc_nx   = if_pc;
    instr_nx = if_instr;
    mis_nx   = if_misalign;
    halt_nx  = halt;
    req_c    = 1'b0;

    if (id_ready) begin
      valid_nx = 1'b0;
      mis_nx   = 1'b0;
    end

    unique case (state)
      ISSUE: begin
        if (!halt && (!if_valid || id_ready) && !redirect) begin
          req_c    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (imem.ack) begin
          valid_nx = 1'b1;
          bpc_nx   = pc;
          instr_nx = imem.rdata;
          mis_nx   = 1'b0;
          pc_nx    = pc + 32'd4;
          state_nx = ISSUE;
        end
      end
      DROP: begin
        if (imem.ack) state_nx = ISSUE;
      end
      default: state_nx = ISSUE;
    endcase

    // Redirect overrides any capture/increment decided above.
    if (redirect) begin
      pc_nx    = target;
      valid_nx = 1'b0;
      mis_nx   = 1'b0;
      halt_nx  = tgt_fault;
      if (state == WAIT && !imem.ack) state_nx = DROP;
      if (tgt_fault) begin
        valid_nx = 1'b1;
        bpc_nx   = target;
        instr_nx = NOP_INSTR;
        mis_nx   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= NOP_INSTR;
      if_misalign <= 1'b0;
      halt        <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      if_valid    <= valid_nx;
      if_pc       <= bpc_nx;
      if_instr    <= instr_nx;
      if_misalign <= mis_nx;
      halt        <= halt_nx;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs change and outputs are sampled after negedge.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_offset;
  logic [31:0] br_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .br_pc       (br_pc),
    .id_ready    (id_ready),
    .imem        (imem),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_misalign (if_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; br_taken = 1'b0; br_offset = '0; br_pc = '0; id_ready = 1'b0;
    imem.ack = 1'b0; imem.rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (imem.req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%b exp=0", imem.req); end
    vectors++; if (imem.addr !== 32'h8000_0000) begin miscompares++; $display("FAIL reset_addr got=%h exp=80000000", imem.addr); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
    vectors++; if (if_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_instr got=%h exp=00000013", if_instr); end
    vectors++; if (if_misalign !== 1'b0) begin miscompares++; $display("FAIL reset_mis got=%b exp=0", if_misalign); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fetch_seq();
    @(negedge clk); id_ready = 1'b1; imem.ack = 1'b1; imem.rdata = 32'h0010_0093; #1;
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0000) begin miscompares++; $display("FAIL seq_req0 got=%b/%h exp=1/80000000", imem.req, imem.addr); end
    @(negedge clk); imem.ack = 1'b0; #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000 || if_instr !== 32'h0010_0093) begin miscompares++; $display("FAIL seq_buf0 got=%b/%h/%h exp=1/80000000/00100093", if_valid, if_pc, if_instr); end
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0004) begin miscompares++; $display("FAIL seq_req1 got=%b/%h exp=1/80000004", imem.req, imem.addr); end
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'h0020_0113; #1;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL seq_drained got=%b exp=0", if_valid); end
    @(negedge clk); imem.ack = 1'b0; #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0004 || if_instr !== 32'h0020_0113) begin miscompares++; $display("FAIL seq_buf1 got=%b/%h/%h exp=1/80000004/00200113", if_valid, if_pc, if_instr); end
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0008) begin miscompares++; $display("FAIL seq_req2 got=%b/%h exp=1/80000008", imem.req, imem.addr); end
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'h0030_0193; #1;
    @(negedge clk); imem.ack = 1'b0; id_ready = 1'b0; #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0008 || if_instr !== 32'h0030_0193) begin miscompares++; $display("FAIL seq_buf2 got=%b/%h/%h exp=1/80000008/00300193", if_valid, if_pc, if_instr); end
    vectors++; if (imem.req !== 1'b0) begin miscompares++; $display("FAIL seq_full_noreq got=%b exp=0", imem.req); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      vectors++; if (imem.req !== 1'b0 || if_valid !== 1'b1) begin miscompares++; $display("FAIL stall_cyc%0d req/valid got=%b/%b exp=0/1", i, imem.req, if_valid); end
    end
    @(negedge clk); id_ready = 1'b1; #1;
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_000C) begin miscompares++; $display("FAIL stall_release got=%b/%h exp=1/8000000c", imem.req, imem.addr); end
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'h0040_0213; #1;
    @(negedge clk); imem.ack = 1'b0; #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_000C) begin miscompares++; $display("FAIL stall_buf got=%b/%h exp=1/8000000c", if_valid, if_pc); end
  endtask

  task automatic test_redirect_wait();
    @(negedge clk); br_taken = 1'b1; br_pc = 32'h8000_0010; br_offset = 32'hFFFF_FFF0; #1;
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0010) begin miscompares++; $display("FAIL rw_wait got=%b/%h exp=1/80000010", imem.req, imem.addr); end
    @(negedge clk); br_taken = 1'b0; #1;
    vectors++; if (imem.req !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL rw_drop1 req/valid got=%b/%b exp=0/0", imem.req, if_valid); end
    @(negedge clk); #1;
    vectors++; if (imem.req !== 1'b0) begin miscompares++; $display("FAIL rw_drop2 got=%b exp=0", imem.req); end
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF; #1;
    vectors++; if (imem.req !== 1'b0) begin miscompares++; $display("FAIL rw_drop_ack got=%b exp=0", imem.req); end
    @(negedge clk); imem.ack = 1'b0; #1;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rw_discard got=%b exp=0", if_valid); end
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rw_target got=%b/%h exp=1/80000000", imem.req, imem.addr); end
  endtask

  task automatic test_redirect_ack();
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'hBAD0_BAD0;
    br_taken = 1'b1; br_pc = 32'h8000_0004; br_offset = 32'h0000_0020; #1;
    @(negedge clk); imem.ack = 1'b0; br_taken = 1'b0; #1;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL ra_discard got=%b exp=0", if_valid); end
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0024) begin miscompares++; $display("FAIL ra_target got=%b/%h exp=1/80000024", imem.req, imem.addr); end
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'h0050_0293; #1;
    @(negedge clk); imem.ack = 1'b0; id_ready = 1'b0; #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0024 || if_instr !== 32'h0050_0293) begin miscompares++; $display("FAIL ra_buf got=%b/%h/%h exp=1/80000024/00500293", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_redirect_issue();
    @(negedge clk); id_ready = 1'b1; br_taken = 1'b1; br_pc = 32'h8000_0100; br_offset = 32'h0000_0040; #1;
    @(negedge clk); br_taken = 1'b0; #1;
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0140 || if_valid !== 1'b0) begin miscompares++; $display("FAIL ri_target got=%b/%h/%b exp=1/80000140/0", imem.req, imem.addr, if_valid); end
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'h0060_0313; #1;
    @(negedge clk); imem.ack = 1'b0; #1;
    vectors++; if (if_pc !== 32'h8000_0140 || imem.addr !== 32'h8000_0144) begin miscompares++; $display("FAIL ri_next got=%h/%h exp=80000140/80000144", if_pc, imem.addr); end
  endtask

  task automatic test_odd_target();
    @(negedge clk); br_taken = 1'b1; br_pc = 32'h8000_0100; br_offset = 32'h0000_0001; #1;
    @(negedge clk); br_taken = 1'b0; imem.ack = 1'b1; imem.rdata = 32'h1111_1111; #1;
    vectors++; if (imem.req !== 1'b0) begin miscompares++; $display("FAIL odd_drop got=%b exp=0", imem.req); end
    @(negedge clk); imem.ack = 1'b0; #1;
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0100) begin miscompares++; $display("FAIL odd_addr got=%b/%h exp=1/80000100", imem.req, imem.addr); end
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'h0070_0393; #1;
    @(negedge clk); imem.ack = 1'b0; #1;
    vectors++; if (if_pc !== 32'h8000_0100 || if_instr !== 32'h0070_0393 || if_misalign !== 1'b0) begin miscompares++; $display("FAIL odd_buf got=%h/%h/%b exp=80000100/00700393/0", if_pc, if_instr, if_misalign); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    @(negedge clk); br_taken = 1'b1; br_pc = 32'h8000_0100; br_offset = 32'h0000_0002; #1;
    @(negedge clk); br_taken = 1'b0; id_ready = 1'b0; imem.ack = 1'b1; imem.rdata = 32'h2222_2222; #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0102 || if_instr !== 32'h0000_0013 || if_misalign !== 1'b1) begin miscompares++; $display("FAIL mis_entry got=%b/%h/%h/%b exp=1/80000102/00000013/1", if_valid, if_pc, if_instr, if_misalign); end
    vectors++; if (imem.req !== 1'b0) begin miscompares++; $display("FAIL mis_drop got=%b exp=0", imem.req); end
    @(negedge clk); imem.ack = 1'b0; id_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++; if (imem.req !== 1'b0) begin miscompares++; $display("FAIL mis_halt%0d got=%b exp=0", i, imem.req); end
    end
    @(negedge clk); br_taken = 1'b1; br_pc = 32'h8000_0200; br_offset = 32'h0; #1;
    @(negedge clk); br_taken = 1'b0; #1;
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0200 || if_misalign !== 1'b0) begin miscompares++; $display("FAIL mis_recover got=%b/%h/%b exp=1/80000200/0", imem.req, imem.addr, if_misalign); end
  endtask
`endif

  task automatic test_reset_midwait();
    @(negedge clk); #2; rst_n = 1'b0; #1;
    vectors++; if (imem.req !== 1'b0 || imem.addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rst_bus got=%b/%h exp=0/80000000", imem.req, imem.addr); end
    vectors++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0000_0013 || if_misalign !== 1'b0) begin miscompares++; $display("FAIL rst_buf got=%b/%h/%h/%b exp=0/0/00000013/0", if_valid, if_pc, if_instr, if_misalign); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); imem.ack = 1'b1; imem.rdata = 32'h0080_0413; #1;
    vectors++; if (imem.req !== 1'b1 || imem.addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rst_restart got=%b/%h exp=1/80000000", imem.req, imem.addr); end
    @(negedge clk); imem.ack = 1'b0; #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000 || if_instr !== 32'h0080_0413) begin miscompares++; $display("FAIL rst_first got=%b/%h/%h exp=1/80000000/00800413", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_redirect_issue();
    test_odd_target();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_reset_midwait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
